regression_seq_controller: RTL and testbench

- Parametrised sequencing controller for the linear-regression datapath.
- Loads a runtime-selectable number of (x,y) samples into sample memory over a valid/ready stream.
- Then drives the mean, coefficient-calculation and error units in order, with the calc phase repeated for a programmable number of epochs.
- Owns the sample address counter; sits between the host/load interface and the mean/calc/error units. Adds abort support.

---
 rtl/regression_seq_controller.sv | 232 +++++++++++++++++++++++
 tb/tb_regression_seq_controller.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regression_seq_controller.sv
// regression_seq_controller
//
// Sequencing controller for the linear-regression datapath. A run loads
// `len` (x,y) samples into sample memory over a valid/ready stream, then
// walks the sample memory once for the mean unit, `epochs` times for the
// coefficient-calculation unit (one sample per request/acknowledge pair),
// and once more for the error unit. `abort` cancels a run at any point.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   start         begin a run (sampled only while idle)
//   abort         cancel the current run, return to idle without done
//   len           number of samples, latched at start (0 = empty run)
//   epochs        calc-phase repetitions, latched at start (0 behaves as 1)
//   in_valid      load stream: sample present
//   in_ready      load stream: controller accepting
//   mem_we        sample memory write enable
//   addr          sample memory address
//   xy_valid      sample at addr presented to the active unit
//   mean_start    mean unit start request     / mean_ready  its acknowledge
//   calc_start    calc unit start request     / calc_ready  its acknowledge
//   err_start     error unit start request    / err_ready   its acknowledge
//   err_done      per-sample error accumulate strobe
//   epoch         current calc epoch, 0-based
//   busy          high whenever a run is in progress
//   done          one-cycle pulse on run completion

module regression_seq_controller #(
    parameter int ADDR_W  = 8,
    parameter int EPOCH_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  len,
    input  logic [EPOCH_W-1:0] epochs,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  addr,
    output logic               xy_valid,
    output logic               mean_start,
    output logic               calc_start,
    output logic               err_start,
    input  logic               mean_ready,
    input  logic               calc_ready,
    input  logic               err_ready,
    output logic               err_done,
    output logic [EPOCH_W-1:0] epoch,
    output logic               busy,
    output logic               done
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        MEAN_REQ,
        MEAN_SEND,
        CALC_REQ,
        CALC_SEND,
        CALC_WAIT,
        ERR_REQ,
        ERR_SEND,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  addr_next;
    logic [EPOCH_W-1:0] epoch_next;
    logic [ADDR_W-1:0]  len_q;
    logic [ADDR_W-1:0]  len_next;
    logic [EPOCH_W-1:0] ep_q;
    logic [EPOCH_W-1:0] ep_next;
    logic               last;
    logic               last_epoch;

    // len_q is never zero outside IDLE, so len_q-1 cannot underflow where
    // last is consulted.
    assign last       = (addr == len_q - ADDR_W'(1));
    assign last_epoch = (epoch >= ep_q - EPOCH_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
            epoch <= '0;
            len_q <= '0;
            ep_q  <= '0;
        end else begin
            state <= state_next;
            addr  <= addr_next;
            epoch <= epoch_next;
            len_q <= len_next;
            ep_q  <= ep_next;
        end
    end

    always_comb begin
        state_next = state;
        addr_next  = addr;
        epoch_next = epoch;
        len_next   = len_q;
        ep_next    = ep_q;

        in_ready   = 1'b0;
        mem_we     = 1'b0;
        xy_valid   = 1'b0;
        mean_start = 1'b0;
        calc_start = 1'b0;
        err_start  = 1'b0;
        err_done   = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        // Empty run: skip every phase, still report completion.
                        state_next = DONE;
                    end else begin
                        len_next   = len;
                        ep_next    = (epochs == '0) ? EPOCH_W'(1) : epochs;
                        addr_next  = '0;
                        epoch_next = '0;
                        state_next = LOAD;
                    end
                end
            end

            LOAD: begin
                in_ready = 1'b1;
                mem_we   = in_valid;
                if (in_valid) begin
                    if (last) begin
                        addr_next  = '0;
                        state_next = MEAN_REQ;
                    end else begin
                        addr_next = addr + ADDR_W'(1);
                    end
                end
            end

            MEAN_REQ: begin
                mean_start = 1'b1;
                if (mean_ready) begin
                    state_next = MEAN_SEND;
                end
            end

            MEAN_SEND: begin
                xy_valid = 1'b1;
                if (last) begin
                    addr_next  = '0;
                    state_next = CALC_REQ;
                end else begin
                    addr_next = addr + ADDR_W'(1);
                end
            end

            CALC_REQ: begin
                calc_start = 1'b1;
                if (calc_ready) begin
                    state_next = CALC_SEND;
                end
            end

            // The calc unit consumes one sample per acknowledge, so ready is
            // only looked at in CALC_WAIT, after the sample has been offered.
            CALC_SEND: begin
                xy_valid   = 1'b1;
                state_next = CALC_WAIT;
            end

            CALC_WAIT: begin
                if (calc_ready) begin
                    if (!last) begin
                        addr_next  = addr + ADDR_W'(1);
                        state_next = CALC_SEND;
                    end else if (!last_epoch) begin
                        addr_next  = '0;
                        epoch_next = epoch + EPOCH_W'(1);
                        state_next = CALC_REQ;
                    end else begin
                        addr_next  = '0;
                        state_next = ERR_REQ;
                    end
                end
            end

            ERR_REQ: begin
                err_start = 1'b1;
                if (err_ready) begin
                    state_next = ERR_SEND;
                end
            end

            ERR_SEND: begin
                xy_valid = 1'b1;
                err_done = 1'b1;
                if (last) begin
                    addr_next  = '0;
                    state_next = DONE;
                end else begin
                    addr_next = addr + ADDR_W'(1);
                end
            end

            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                addr_next  = '0;
                epoch_next = '0;
            end
        endcase

        // Abort overrides whatever transition the current state chose; the
        // decoded outputs above (including a LOAD write) still apply this cycle.
        if (abort && (state != IDLE)) begin
            state_next = IDLE;
            addr_next  = '0;
            epoch_next = '0;
        end
    end

endmodule

// File: tb/tb_regression_seq_controller.sv
module tb_regression_seq_controller;

    localparam int ADDR_W  = 8;
    localparam int EPOCH_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [ADDR_W-1:0]  len = '0;
    logic [EPOCH_W-1:0] epochs = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               mem_we;
    logic [ADDR_W-1:0]  addr;
    logic               xy_valid;
    logic               mean_start;
    logic               calc_start;
    logic               err_start;
    logic               mean_ready = 1'b0;
    logic               calc_ready = 1'b0;
    logic               err_ready = 1'b0;
    logic               err_done;
    logic [EPOCH_W-1:0] epoch;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    regression_seq_controller #(
        .ADDR_W (ADDR_W),
        .EPOCH_W(EPOCH_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .len       (len),
        .epochs    (epochs),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .addr      (addr),
        .xy_valid  (xy_valid),
        .mean_start(mean_start),
        .calc_start(calc_start),
        .err_start (err_start),
        .mean_ready(mean_ready),
        .calc_ready(calc_ready),
        .err_ready (err_ready),
        .err_done  (err_done),
        .epoch     (epoch),
        .busy      (busy),
        .done      (done)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Stimulus control, written only by the main process.
    int vmode  = 0;    // 0: in_valid high, 1: toggling, 2: random
    int rmode  = 0;    // 0: readies high, 1: random
    bit tog    = 1'b1;
    int cur_len = 0;
    int cur_ep  = 1;

    // Event log, written only by the monitor. Checks use snapshots of sizes.
    int wq[$];
    int mq[$];
    int cq[$];
    int erq[$];
    int n_ms = 0, n_cs = 0, n_es = 0, n_done = 0, n_bad = 0;
    bit in_calc = 1'b0;
    bit p_ms = 1'b0, p_cs = 1'b0, p_es = 1'b0;

    always @(negedge clk) begin
        if (mem_we) wq.push_back(int'(addr));
        if (xy_valid && err_done)      erq.push_back(int'(addr));
        else if (xy_valid && in_calc)  cq.push_back(int'(epoch) * 256 + int'(addr));
        else if (xy_valid)             mq.push_back(int'(addr));
        if (mean_start && !p_ms) n_ms++;
        if (calc_start && !p_cs) n_cs++;
        if (err_start && !p_es)  n_es++;
        if (done) n_done++;
        if (mem_we && !in_ready) n_bad++;
        if (err_done && !xy_valid) n_bad++;
        if (busy && cur_len > 0 && int'(addr) >= cur_len) n_bad++;
        if (busy && int'(epoch) >= ((cur_ep == 0) ? 1 : cur_ep)) n_bad++;
        if (calc_start) in_calc = 1'b1;
        else if (err_start || !busy) in_calc = 1'b0;
        p_ms = mean_start;
        p_cs = calc_start;
        p_es = err_start;
    end

    typedef struct {
        int bw, bm, bc, be, bms, bcs, bes, bdone, bbad;
    } snap_t;

    function automatic snap_t mark();
        snap_t s;
        s.bw = wq.size();  s.bm = mq.size(); s.bc = cq.size(); s.be = erq.size();
        s.bms = n_ms; s.bcs = n_cs; s.bes = n_es; s.bdone = n_done; s.bbad = n_bad;
        return s;
    endfunction

    task automatic drive_cycle();
        case (vmode)
            0:       in_valid = 1'b1;
            1:       begin in_valid = tog; tog = !tog; end
            default: in_valid = 1'($urandom_range(0, 1));
        endcase
        if (rmode == 0) begin
            mean_ready = 1'b1; calc_ready = 1'b1; err_ready = 1'b1;
        end else begin
            mean_ready = ($urandom_range(0, 3) != 0);
            calc_ready = ($urandom_range(0, 3) != 0);
            err_ready  = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clk);
        #1;
        drive_cycle();
    endtask

    // Raises start, counts clock edges from the one sampling start to the
    // one after which done is visible.
    task automatic go(input int budget, input bit hold, output int edges);
        start = 1'b1;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            if (!hold) start = 1'b0;
            edges++;
            drive_cycle();
        end while (!done && edges < budget);
        start = 1'b0;
    endtask

    // Reference: each phase visits addresses 0..len-1 in order; the calc
    // phase does so once per effective epoch with epoch tagging each sample.
    task automatic check_stream(input string name, input int q[$], input int base,
                                input int exp[$]);
        int n;
        int mis;
        n   = q.size() - base;
        mis = 0;
        check({name, "_count"}, n, exp.size());
        for (int i = 0; i < n && i < exp.size(); i++)
            if (q[base + i] != exp[i]) mis++;
        check({name, "_order"}, mis, 0);
    endtask

    task automatic check_run(input string tag, input int l, input int e, input snap_t s);
        int eff;
        int ew[$];
        int ec[$];
        eff = (e == 0) ? 1 : e;
        for (int a = 0; a < l; a++) ew.push_back(a);
        if (l > 0)
            for (int k = 0; k < eff; k++)
                for (int a = 0; a < l; a++) ec.push_back(k * 256 + a);
        check_stream({tag, "_writes"}, wq, s.bw, ew);
        check_stream({tag, "_mean"}, mq, s.bm, ew);
        check_stream({tag, "_calc"}, cq, s.bc, ec);
        check_stream({tag, "_err"}, erq, s.be, ew);
        check({tag, "_mean_starts"}, n_ms - s.bms, (l > 0) ? 1 : 0);
        check({tag, "_calc_starts"}, n_cs - s.bcs, (l > 0) ? eff : 0);
        check({tag, "_err_starts"}, n_es - s.bes, (l > 0) ? 1 : 0);
        check({tag, "_done_pulses"}, n_done - s.bdone, 1);
        check({tag, "_protocol"}, n_bad - s.bbad, 0);
    endtask

    typedef struct {
        string name;
        int    l;
        int    e;
        int    vm;
        int    lat;      // edges from start sample to done visible
        int    calc_xy;
        int    err_n;
    } vec_t;

    task automatic run_case(input vec_t v);
        snap_t s;
        int    edges;
        len = ADDR_W'(v.l); epochs = EPOCH_W'(v.e);
        cur_len = v.l; cur_ep = v.e;
        vmode = v.vm; rmode = 0; tog = 1'b1;
        s = mark();
        go(5000, 1'b0, edges);
        check({v.name, "_latency"}, edges, v.lat);
        check({v.name, "_done"}, done, 1);
        wait_cycle();
        check({v.name, "_idle_busy"}, busy, 0);
        check({v.name, "_idle_done"}, done, 0);
        check({v.name, "_calc_xy"}, cq.size() - s.bc, v.calc_xy);
        check({v.name, "_err_done"}, erq.size() - s.be, v.err_n);
        check_run(v.name, v.l, v.e, s);
    endtask

    initial begin
        vec_t  vt[$];
        snap_t s;
        int    edges;
        bit    found;
        int    l, e;

        vt.push_back('{"basic4",  4,   1, 0, 24,   4,   4});
        vt.push_back('{"ep3",     3,   3, 0, 33,   9,   3});
        vt.push_back('{"toggle5", 5,   1, 1, 33,   5,   5});
        vt.push_back('{"len0",    0,   2, 0, 1,    0,   0});
        vt.push_back('{"len1ep0", 1,   0, 0, 9,    1,   1});
        vt.push_back('{"maxlen",  255, 1, 0, 1279, 255, 255});
        vt.push_back('{"ep15",    2,  15, 0, 84,   30,  2});

        // Reset state.
        drive_cycle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_addr", addr, 0);
        check("rst_epoch", epoch, 0);
        check("rst_outs", {in_ready, mem_we, xy_valid, mean_start, calc_start,
                           err_start, err_done, done}, 0);
        rst = 1'b0;
        wait_cycle();

        foreach (vt[i]) run_case(vt[i]);

        // Abort in CALC_WAIT of epoch 1 at address 2.
        len = 8'd4; epochs = 4'd3; cur_len = 4; cur_ep = 3; vmode = 0; rmode = 0;
        s = mark();
        start = 1'b1;
        wait_cycle();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (busy && epoch == 4'd1 && addr == 8'd2 && !xy_valid) found = 1'b1;
            else wait_cycle();
        end
        check("abort_reached_calc_wait", found, 1);
        abort = 1'b1;
        wait_cycle();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_addr", addr, 0);
        check("abort_epoch", epoch, 0);
        check("abort_done", done, 0);
        wait_cycle();
        check("abort_no_done_pulse", n_done - s.bdone, 0);
        run_case('{"after_abort", 3, 1, 0, 19, 3, 3});

        // start held high; len changed while busy; rst pulsed in MEAN_SEND.
        len = 8'd3; epochs = 4'd1; cur_len = 3; cur_ep = 1; vmode = 0; rmode = 0;
        s = mark();
        start = 1'b1;
        wait_cycle();
        len = 8'd7;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (xy_valid) found = 1'b1;
            else wait_cycle();
        end
        check("hold_reached_mean_send", found, 1);
        check("hold_writes_use_latched_len", wq.size() - s.bw, 3);
        rst = 1'b1;
        wait_cycle();
        check("midrst_busy", busy, 0);
        check("midrst_addr", addr, 0);
        check("midrst_epoch", epoch, 0);
        check("midrst_outs", {in_ready, mem_we, xy_valid, mean_start, calc_start,
                              err_start, err_done, done}, 0);
        rst = 1'b0;
        cur_len = 7;
        s = mark();
        go(5000, 1'b1, edges);
        check("hold_latency", edges, 39);
        wait_cycle();
        check("hold_idle_busy", busy, 0);
        check_run("hold", 7, 1, s);

        // Randomized runs with stalls on every handshake.
        for (int r = 0; r < 20; r++) begin
            l = $urandom_range(1, 12);
            e = $urandom_range(0, 4);
            len = ADDR_W'(l); epochs = EPOCH_W'(e);
            cur_len = l; cur_ep = e; vmode = 2; rmode = 1;
            s = mark();
            go(5000, 1'b0, edges);
            check("rand_done_seen", done, 1);
            wait_cycle();
            check("rand_idle_busy", busy, 0);
            check_run("rand", l, e, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
